// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the
// byte-addressed data memory. One transaction outstanding at a time.
//   clock, reset          : system clock, synchronous active-high reset
//   pN_req/we/memop/addr  : port N request (N=0 LSU, N=1 DMA/debug)
//   pN_wdata              : port N store data, LSB-aligned
//   pN_gnt, pN_done       : accept pulse, completion pulse
//   pN_rdata              : extended load result (held between loads)
//   mem_addr/rd/rdata     : memory read side, rdata valid cycle after rd
//   mem_we/wdata          : memory full-word write side
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_memop,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [2:0]        p1_memop,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [31:0]       p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

    state_t            state;
    state_t            state_nx;
    logic              rr;
    logic              l_we;
    logic [2:0]        l_op;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_data;
    logic              l_port;
    logic [31:0]       hold0;
    logic [31:0]       hold1;

    logic              take;
    logic              sel;
    logic              s_we;
    logic [2:0]        s_op;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [31:0]       ext;
    logic [31:0]       merged;

    function automatic logic bad_op(input logic [2:0] op);
        return (op == 3'b011) || (op[2:1] == 2'b11);
    endfunction

    // rr remembers the port served last; a tie goes to the other one.
    always_comb begin
        take = p0_req | p1_req;
        sel  = (p0_req && p1_req) ? ~rr : p1_req;
        s_we    = sel ? p1_we    : p0_we;
        s_op    = sel ? p1_memop : p0_memop;
        s_addr  = sel ? p1_addr  : p0_addr;
        s_wdata = sel ? p1_wdata : p0_wdata;
    end

    always_comb begin
        case (l_op)
            3'b000:  ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b010:  ext = mem_rdata;
            3'b100:  ext = {24'h0, mem_rdata[7:0]};
            3'b101:  ext = {16'h0, mem_rdata[15:0]};
            default: ext = 32'h0;
        endcase
        // Only byte and half stores take the read-modify-write path.
        if (l_op[0])
            merged = {mem_rdata[31:16], l_data[15:0]};
        else
            merged = {mem_rdata[31:8], l_data[7:0]};
    end

    // Outputs are suppressed while reset is high so an aborted
    // transaction never signals completion or writes memory.
    always_comb begin
        state_nx  = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        p0_rdata  = hold0;
        p1_rdata  = hold1;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (take) begin
                        p0_gnt = ~sel;
                        p1_gnt = sel;
                        if (s_we && (s_op == 3'b010 || bad_op(s_op)))
                            state_nx = WR;
                        else
                            state_nx = RD;
                    end
                end
                RD: begin
                    mem_rd   = 1'b1;
                    mem_addr = l_addr;
                    state_nx = WAIT;
                end
                WAIT: begin
                    mem_addr = l_addr;
                    if (l_we) begin
                        state_nx = WR;
                    end else begin
                        p0_done  = ~l_port;
                        p1_done  = l_port;
                        if (l_port) p1_rdata = ext;
                        else        p0_rdata = ext;
                        state_nx = IDLE;
                    end
                end
                WR: begin
                    mem_addr = l_addr;
                    if (!bad_op(l_op)) begin
                        mem_we    = 1'b1;
                        mem_wdata = l_data;
                    end
                    p0_done  = ~l_port;
                    p1_done  = l_port;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rr     <= 1'b1;
            l_we   <= 1'b0;
            l_op   <= 3'b0;
            l_addr <= '0;
            l_data <= 32'h0;
            l_port <= 1'b0;
            hold0  <= 32'h0;
            hold1  <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && take) begin
                rr     <= sel;
                l_port <= sel;
                l_we   <= s_we;
                l_op   <= s_op;
                l_addr <= s_addr;
                l_data <= s_wdata;
            end
            if (state == WAIT) begin
                if (l_we)
                    l_data <= merged;
                else if (l_port)
                    hold1 <= ext;
                else
                    hold0 <= ext;
            end
        end
    end

endmodule
